// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one multiplier bit per clock, unsigned or
// two's-complement per operation, valid/ready handshakes on both sides.
module mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 sgn,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   x,
   output logic                 busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    acc_q, mcand_q, acc_sum;
   logic [WIDTH-1:0] mplier_q, a_mag, b_mag;
   logic [CW-1:0]    count_q;
   logic             neg_q, last;

   // Handshakes: a transfer happens on a rising clk edge where valid and ready
   // are both high; valid never drops and x never changes before that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign last = (count_q == CW'(WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            busy = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Magnitudes as W-bit unsigned; the most negative value maps to 2^(W-1).
   assign a_mag   = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign b_mag   = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
   assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         x         <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                  mplier_q <= b_mag;
                  acc_q    <= '0;
                  count_q  <= '0;
                  neg_q    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
               end
            end
            CALC: begin
               acc_q    <= acc_sum;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + CW'(1);
               if (last) begin
                  x         <= neg_q ? (~acc_sum + PW'(1)) : acc_sum;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed vector table at W=8, handshake/reject/reset
// sequences, and random W=16 operations against a behavioural product.
module tb_mult_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] x8;

   logic        in_valid16, in_ready16, sgn16, out_valid16, out_ready16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] x16;

   mult_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .sgn(sgn8), .out_valid(out_valid8), .out_ready(out_ready8),
      .x(x8), .busy(busy8));

   mult_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .sgn(sgn16), .out_valid(out_valid16), .out_ready(out_ready16),
      .x(x16), .busy(busy16));

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Starts at a point just after a rising edge with the DUT idle.
   task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                      output logic [15:0] res, output int lat);
      in_valid8 = 1'b1; a8 = ia; b8 = ib; sgn8 = is;
      @(posedge clk); #1;
      in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~is;
      lat = 0;
      while (!out_valid8 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      res = x8;
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
   endtask

   task automatic op16(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                       output logic [31:0] res, output int lat);
      in_valid16 = 1'b1; a16 = ia; b16 = ib; sgn16 = is;
      @(posedge clk); #1;
      in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      lat = 0;
      while (!out_valid16 && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      res = x16;
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sgn;
      logic [15:0] x;
   } vec_t;

   vec_t vecs[16];

   initial begin
      logic [15:0] r8, hx;
      logic [31:0] r16, e16;
      logic [15:0] ra, rb;
      logic [7:0]  qa, qb;
      int          lat, extra, sa, sb;

      vecs[0]  = '{8'd255, 8'd255, 1'b0, 16'hFE01};
      vecs[1]  = '{8'd0,   8'd200, 1'b0, 16'h0000};
      vecs[2]  = '{8'd3,   8'd5,   1'b0, 16'h000F};
      vecs[3]  = '{8'd7,   8'd9,   1'b0, 16'h003F};
      vecs[4]  = '{8'd100, 8'd200, 1'b0, 16'h4E20};
      vecs[5]  = '{8'd128, 8'd2,   1'b0, 16'h0100};
      vecs[6]  = '{8'd1,   8'd255, 1'b0, 16'h00FF};
      vecs[7]  = '{8'd12,  8'd12,  1'b0, 16'h0090};
      vecs[8]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
      vecs[9]  = '{8'h80,  8'h7F,  1'b1, 16'hC080};
      vecs[10] = '{8'hFF,  8'h01,  1'b1, 16'hFFFF};
      vecs[11] = '{8'h7F,  8'h7F,  1'b1, 16'h3F01};
      vecs[12] = '{8'hFF,  8'h00,  1'b1, 16'h0000};
      vecs[13] = '{8'hFE,  8'h03,  1'b1, 16'hFFFA};
      vecs[14] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
      vecs[15] = '{8'h85,  8'h10,  1'b1, 16'hF850};

      rst_n = 1'b0;
      in_valid8 = 0; a8 = 0; b8 = 0; sgn8 = 0; out_ready8 = 0;
      in_valid16 = 0; a16 = 0; b16 = 0; sgn16 = 0; out_ready16 = 0;
      #3;
      check("reset in_ready",  32'(in_ready8),  32'd1);
      check("reset busy",      32'(busy8),      32'd0);
      check("reset out_valid", 32'(out_valid8), 32'd0);
      check("reset x",         32'(x8),         32'd0);
      check("reset x16",       x16,             32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table at W=8
      foreach (vecs[i]) begin
         op8(vecs[i].a, vecs[i].b, vecs[i].sgn, r8, lat);
         check($sformatf("vec%0d x", i), 32'(r8), 32'(vecs[i].x));
         check($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
      end

      // Random W=8 in both modes against the bench's own product
      for (int i = 0; i < 200; i++) begin
         qa = 8'($urandom_range(0, 255));
         qb = 8'($urandom_range(0, 255));
         op8(qa, qb, 1'(i & 1), r8, lat);
         if (i & 1) e16 = 32'(int'($signed(qa)) * int'($signed(qb)));
         else       e16 = {16'b0, qa} * {16'b0, qb};
         check("rand8 x", 32'(r8), {16'b0, e16[15:0]});
      end

      // Handshake: hold out_ready low in DONE, then release
      in_valid8 = 1'b1; a8 = 8'd10; b8 = 8'd11; sgn8 = 1'b0;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      check("hs early out_valid", 32'(out_valid8), 32'd0);
      @(posedge clk); #1;
      check("hs out_valid at E+8", 32'(out_valid8), 32'd1);
      hx = x8;
      check("hs x", 32'(hx), 32'h006E);
      repeat (5) begin
         @(posedge clk); #1;
         check("hs hold out_valid", 32'(out_valid8), 32'd1);
         check("hs hold x", 32'(x8), 32'(hx));
         check("hs hold in_ready", 32'(in_ready8), 32'd0);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      check("hs release in_ready", 32'(in_ready8), 32'd1);
      check("hs release out_valid", 32'(out_valid8), 32'd0);
      check("hs release busy", 32'(busy8), 32'd0);
      check("hs x kept", 32'(x8), 32'h006E);
      @(posedge clk); #1;
      check("hs out_ready idle no effect", 32'(in_ready8), 32'd1);

      // Busy rejection: a second request stays asserted through CALC and DONE
      in_valid8 = 1'b1; a8 = 8'd7; b8 = 8'd9; sgn8 = 1'b0;
      @(posedge clk); #1;
      a8 = 8'd3; b8 = 8'd5;
      repeat (3) begin @(posedge clk); #1; end
      check("rej busy in CALC", 32'(busy8), 32'd1);
      repeat (5) begin @(posedge clk); #1; end
      check("rej out_valid", 32'(out_valid8), 32'd1);
      check("rej x", 32'(x8), 32'h003F);
      repeat (3) begin @(posedge clk); #1; end
      check("rej x held", 32'(x8), 32'h003F);
      check("rej in_ready DONE", 32'(in_ready8), 32'd0);
      in_valid8 = 1'b0; out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      extra = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid8 || busy8) extra++;
      end
      check("rej single result", 32'(extra), 32'd0);

      // Reset three clocks into CALC
      in_valid8 = 1'b1; a8 = 8'h55; b8 = 8'h33; sgn8 = 1'b0;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(out_valid8), 32'd0);
      check("rst x", 32'(x8), 32'd0);
      check("rst in_ready", 32'(in_ready8), 32'd1);
      check("rst busy", 32'(busy8), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      op8(8'd12, 8'd12, 1'b0, r8, lat);
      check("rst next op x", 32'(r8), 32'h0090);
      check("rst next op latency", 32'(lat), 32'd8);

      // W=16: corner then random in both modes
      op16(16'hFFFF, 16'hFFFF, 1'b0, r16, lat);
      check("w16 max x", r16, 32'hFFFE0001);
      check("w16 latency", 32'(lat), 32'd16);
      op16(16'h8000, 16'h8000, 1'b1, r16, lat);
      check("w16 minneg sq", r16, 32'h40000000);
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            op16(ra, rb, 1'(m), r16, lat);
            if (m == 1) begin
               sa = int'($signed(ra));
               sb = int'($signed(rb));
               e16 = 32'(sa * sb);
            end else begin
               e16 = {16'b0, ra} * {16'b0, rb};
            end
            check(m ? "rand16 signed x" : "rand16 unsigned x", r16, e16);
            if (i < 20) check("rand16 latency", 32'(lat), 32'd16);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
